// File: rtl/user_word_sender.sv
// Frame-level user word transmitter: pulls a clamped word count from upstream per frame
// and presents it on a valid/ready transmit port, marking the final word.
module user_word_sender #(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic [3:0]        i_user_word_count,
  input  logic [DATA_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic              o_tx_last,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [3:0]        o_words_sent,
  output logic              o_clamp_err,
  output logic              o_start_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WORDS);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          remaining_r;
  logic [DATA_W-1:0]   tx_data_r;
  logic                tx_valid_r;
  logic                tx_last_r;
  logic                done_r;
  logic [3:0]          words_sent_r;
  logic                clamp_err_r;
  logic                start_err_r;

  logic [3:0]          req_cnt_s;
  logic                start_ok_s;
  logic                tx_hs_s;
  logic                word_ready_s;
  logic                load_s;

  // Handshake qualifiers and clamped request; ready is combinational from i_tx_ready.
  always_comb begin
    req_cnt_s    = (i_user_word_count > MAX_CNT) ? MAX_CNT : i_user_word_count;
    start_ok_s   = i_frame_start && (state_r == IDLE);
    tx_hs_s      = tx_valid_r && i_tx_ready;
    word_ready_s = (state_r == SEND) && (remaining_r != 4'd0) && (!tx_valid_r || i_tx_ready);
    load_s       = word_ready_s && i_word_valid;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s && (req_cnt_s != 4'd0)) state_nxt_s = SEND;
        else                                   state_nxt_s = IDLE;
      end
      SEND: begin
        if (load_s && (remaining_r == 4'd1)) state_nxt_s = FLUSH;
        else                                 state_nxt_s = SEND;
      end
      FLUSH: begin
        if (tx_hs_s) state_nxt_s = IDLE;
        else         state_nxt_s = FLUSH;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Frame counters, status pulses and the transmit output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      remaining_r  <= 4'd0;
      tx_data_r    <= '0;
      tx_valid_r   <= 1'b0;
      tx_last_r    <= 1'b0;
      done_r       <= 1'b0;
      words_sent_r <= 4'd0;
      clamp_err_r  <= 1'b0;
      start_err_r  <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      clamp_err_r <= 1'b0;
      start_err_r <= 1'b0;
      if (start_ok_s) begin
        remaining_r  <= req_cnt_s;
        words_sent_r <= 4'd0;
        clamp_err_r  <= (i_user_word_count > MAX_CNT);
        done_r       <= (req_cnt_s == 4'd0);
      end else begin
        // A start that arrives while a frame is running is reported, never relatched.
        if (i_frame_start) start_err_r <= 1'b1;
        if (load_s) remaining_r <= remaining_r - 4'd1;
        if (tx_hs_s && (words_sent_r < MAX_CNT)) words_sent_r <= words_sent_r + 4'd1;
        if ((state_r == FLUSH) && tx_hs_s) done_r <= 1'b1;
      end
      if (load_s) begin
        tx_data_r  <= i_word_data;
        tx_valid_r <= 1'b1;
        tx_last_r  <= (remaining_r == 4'd1);
      end else if (tx_hs_s) begin
        tx_valid_r <= 1'b0;
        tx_last_r  <= 1'b0;
      end
    end
  end

  assign o_word_ready = word_ready_s;
  assign o_tx_data    = tx_data_r;
  assign o_tx_valid   = tx_valid_r;
  assign o_tx_last    = tx_last_r;
  assign o_busy       = (state_r != IDLE);
  assign o_done       = done_r;
  assign o_words_sent = words_sent_r;
  assign o_clamp_err  = clamp_err_r;
  assign o_start_err  = start_err_r;

endmodule

// File: tb/tb_user_word_sender.sv
// Scoreboard bench for user_word_sender: frames push expected words and done counts,
// a negedge monitor pops and compares on every transmit handshake and done pulse.
module tb_user_word_sender;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_frame_start;
  logic [3:0]  i_user_word_count;
  logic [31:0] i_word_data;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [31:0] o_tx_data;
  logic        o_tx_valid;
  logic        o_tx_last;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_words_sent;
  logic        o_clamp_err;
  logic        o_start_err;

  user_word_sender #(.DATA_W(32), .MAX_WORDS(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_user_word_count(i_user_word_count), .i_word_data(i_word_data),
    .i_word_valid(i_word_valid), .o_word_ready(o_word_ready), .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_words_sent(o_words_sent),
    .o_clamp_err(o_clamp_err), .o_start_err(o_start_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int rdy_mode = 0;
  bit gap_en = 1'b0;
  bit ready_seen = 1'b0;
  logic [31:0] src_q[$];
  logic [32:0] exp_q[$];
  logic [3:0]  done_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream word source: presents src_q front, pops after each accepted handshake.
  initial begin
    bit hs;
    i_word_valid = 1'b0;
    i_word_data  = 32'h0;
    forever begin
      @(negedge i_clk);
      hs = i_rst_n && i_word_valid && o_word_ready;
      @(posedge i_clk); #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      i_word_valid = (src_q.size() > 0) && (!gap_en || ($urandom_range(0, 1) == 1));
      i_word_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    end
  end

  // Downstream ready: always, random, or held low.
  initial begin
    i_tx_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      case (rdy_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = ($urandom_range(0, 1) == 1);
        default: i_tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] held_data = 32'h0;
    logic        held_last = 1'b0;
    logic [32:0] e;
    forever begin
      @(negedge i_clk);
      if (o_word_ready) ready_seen = 1'b1;
      if (!i_rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("last_qualified", {63'h0, o_tx_last & ~o_tx_valid}, 64'h0);
        if (prev_stall && o_tx_valid) begin
          chk("stall_data_stable", {32'h0, o_tx_data}, {32'h0, held_data});
          chk("stall_last_stable", {63'h0, o_tx_last}, {63'h0, held_last});
        end
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got data %0h, expected no transfer", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", {32'h0, o_tx_data}, {32'h0, e[31:0]});
            chk("tx_last", {63'h0, o_tx_last}, {63'h0, e[32]});
          end
        end
        if (o_done) begin
          done_cyc = cyc;
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done pulse, expected none");
          end else begin
            chk("words_sent_at_done", {60'h0, o_words_sent}, {60'h0, done_q.pop_front()});
          end
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        held_data  = o_tx_data;
        held_last  = o_tx_last;
      end
    end
  end

  // Called at posedge+1: queue expectations, pulse start, check the registered flags.
  task automatic start_frame(input logic [3:0] cnt, input int n, input logic [31:0] base,
                             input bit exp_clamp);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 32'(i));
      exp_q.push_back({(i == n - 1), base + 32'(i)});
    end
    done_q.push_back(4'(n));
    i_user_word_count = cnt;
    i_frame_start = 1'b1;
    start_cyc = cyc;
    @(posedge i_clk); #1;
    i_frame_start = 1'b0;
    @(negedge i_clk);
    chk("clamp_err", {63'h0, o_clamp_err}, {63'h0, exp_clamp});
    chk("start_err_on_accept", {63'h0, o_start_err}, 64'h0);
    chk("busy_after_start", {63'h0, o_busy}, {63'h0, (n != 0)});
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (exp_q.size() == 0 && done_q.size() == 0 && !o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d words and %0d dones pending, expected 0", name,
               exp_q.size(), done_q.size());
      exp_q.delete(); done_q.delete(); src_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    i_rst_n = 1'b0;
    i_frame_start = 1'b0;
    i_user_word_count = 4'd0;
    repeat (2) @(negedge i_clk);
    chk("rst_outputs", {o_tx_data, 16'h0, o_words_sent, 3'h0, o_word_ready, o_tx_valid,
        o_tx_last, o_busy, o_done, o_clamp_err, o_start_err}, 64'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end

    // Three words, no stalls.
    start_frame(4'd3, 3, 32'hA000_0000, 1'b0);
    wait_idle("frame3");
    chk("frame3_done_latency", 64'(done_cyc - start_cyc), 64'd5);
    chk("frame3_words_hold", {60'h0, o_words_sent}, 64'd3);

    // Zero words.
    ready_seen = 1'b0;
    start_frame(4'd0, 0, 32'h0, 1'b0);
    wait_idle("frame0");
    chk("frame0_done_latency", 64'(done_cyc - start_cyc), 64'd1);
    chk("frame0_no_ready", {63'h0, ready_seen}, 64'h0);
    chk("frame0_words", {60'h0, o_words_sent}, 64'd0);

    // Clamped request.
    start_frame(4'd15, 8, 32'hB000_0010, 1'b1);
    wait_idle("frame_clamp");
    chk("clamp_done_latency", 64'(done_cyc - start_cyc), 64'd10);
    chk("clamp_words", {60'h0, o_words_sent}, 64'd8);

    // Five words with gapped valid and random backpressure.
    gap_en = 1'b1;
    rdy_mode = 1;
    @(posedge i_clk); #1;
    start_frame(4'd5, 5, 32'hC000_0100, 1'b0);
    wait_idle("frame_stall");
    gap_en = 1'b0;
    rdy_mode = 0;
    chk("stall_words", {60'h0, o_words_sent}, 64'd5);
    @(posedge i_clk); #1;

    // Restart while busy is rejected; restart coincident with done is accepted.
    start_frame(4'd3, 3, 32'hD000_0200, 1'b0);
    @(posedge i_clk); #1;
    i_user_word_count = 4'd1;
    i_frame_start = 1'b1;
    @(posedge i_clk); #1;
    i_frame_start = 1'b0;
    @(negedge i_clk);
    chk("start_err_busy", {63'h0, o_start_err}, 64'h1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (o_done) begin seen = 1'b1; break; end
    end
    chk("restart_done_seen", {63'h0, seen}, 64'h1);
    start_frame(4'd2, 2, 32'hE000_0300, 1'b0);
    wait_idle("frame_coincident");
    chk("coincident_done_latency", 64'(done_cyc - start_cyc), 64'd4);
    chk("coincident_words", {60'h0, o_words_sent}, 64'd2);

    // Reset while holding the last word in FLUSH.
    rdy_mode = 2;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    start_frame(4'd1, 1, 32'hF000_0400, 1'b0);
    repeat (3) @(negedge i_clk);
    chk("flush_hold", {61'h0, o_busy, o_tx_valid, o_tx_last}, 64'h7);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    exp_q.delete(); done_q.delete(); src_q.delete();
    #1;
    chk("midframe_rst_outputs", {o_tx_data, 16'h0, o_words_sent, 3'h0, o_word_ready,
        o_tx_valid, o_tx_last, o_busy, o_done, o_clamp_err, o_start_err}, 64'h0);
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst_n = 1'b1;
    rdy_mode = 0;
    repeat (5) begin @(posedge i_clk); #1; end
    start_frame(4'd2, 2, 32'h1234_5600, 1'b0);
    wait_idle("frame_after_rst");
    chk("after_rst_done_latency", 64'(done_cyc - start_cyc), 64'd4);
    chk("after_rst_words", {60'h0, o_words_sent}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/user_word_sender.md
# user_word_sender

Frame-level transmitter for user words. It accepts the per-frame user word count produced by the mode/config word-count decoder. On each frame start it pulls exactly that many words from an upstream word buffer and drives them onto the link-side transmit interface with valid/ready handshakes, marking the final word. It sits between the user-word buffer and the frame assembler, one instance per link.

## Interface
- DATA_W, 32, width of one user word
- MAX_WORDS, 8, largest legal count; larger requests are clamped to this value (4'b1000 is the largest value the decoder emits)
- i_clk  input  1  clock, all logic rising-edge
- i_rst_n  input  1  asynchronous active-low reset
- i_frame_start  input  1  single-cycle pulse; latch count and begin a frame
- i_user_word_count  input  4  requested words for this frame, sampled only on i_frame_start
- i_word_data  input  DATA_W  upstream word
- i_word_valid  input  1  upstream word available
- o_word_ready  output  1  block accepts upstream word this cycle
- o_tx_data  output  DATA_W  transmit word
- o_tx_valid  output  1  o_tx_data valid
- o_tx_last  output  1  qualifies the final word of the frame (valid only with o_tx_valid)
- i_tx_ready  input  1  downstream accepts transmit word
- o_busy  output  1  frame in progress
- o_done  output  1  single-cycle pulse at frame completion
- o_words_sent  output  4  transmit handshakes completed in current/last frame
- o_clamp_err  output  1  single-cycle pulse: request exceeded MAX_WORDS
- o_start_err  output  1  single-cycle pulse: i_frame_start while busy

## Operation
- Reset (async assert, sync-released use): state IDLE; all outputs 0; o_tx_data 0; remaining counter 0.
- States: IDLE, SEND, FLUSH.
- IDLE + i_frame_start: remaining <= min(i_user_word_count, MAX_WORDS); o_words_sent <= 0; o_clamp_err pulses if the request exceeds MAX_WORDS.
  - count 0: stay IDLE; o_done pulses next cycle; no transfers occur.
  - count > 0: go to SEND.
- SEND: o_word_ready = (remaining != 0) && (!o_tx_valid || i_tx_ready).
  - On upstream handshake (i_word_valid && o_word_ready):
    - load o_tx_data and set o_tx_valid.
    - set o_tx_last if remaining == 1.
    - remaining decrements.
  - When the last word is loaded, go to FLUSH.
- Output register: o_tx_valid clears on tx handshake (o_tx_valid && i_tx_ready) unless a new word loads the same cycle. Data is held stable while o_tx_valid && !i_tx_ready.
- o_words_sent increments on every tx handshake and saturates at MAX_WORDS. It holds its value after the frame until the next i_frame_start.
- FLUSH: o_word_ready 0. On tx handshake of the last word: o_tx_valid and o_tx_last clear, o_done pulses next cycle, state goes to IDLE.
- o_busy = (state != IDLE).
- i_frame_start in SEND/FLUSH: ignored (count not relatched); o_start_err pulses next cycle.
- i_frame_start in the same cycle o_done is asserted: accepted, because the state is already IDLE.
- Reset mid-frame: the frame is abandoned immediately. No o_done and no o_tx_last are produced.

## Timing
- i_frame_start at cycle N → o_busy high at N+1; o_word_ready may assert at N+1.
- Upstream handshake at cycle M → o_tx_valid/o_tx_data at M+1.
- Throughput is 1 word/cycle with i_word_valid and i_tx_ready held high.
- Frame of K words, no stalls, start at N:
  - words on tx at N+2 .. N+K+1.
  - o_tx_last at N+K+1.
  - o_done at N+K+2; o_busy low at N+K+2.
- Count 0 at N: o_done at N+1; o_busy never rises.
- o_clamp_err and o_start_err are registered, one cycle after the triggering i_frame_start.
- Backpressure: o_word_ready is combinational from i_tx_ready (no skid buffer). Downstream must not make i_tx_ready depend on o_word_ready.

## Test plan
- Count 4'b0011, ready/valid always high: 3 tx words D0..D2 on consecutive cycles, o_tx_last only with D2, o_done 1 cycle after, o_words_sent = 3.
- Count 4'b0000: no o_word_ready, no o_tx_valid, o_done exactly 1 cycle after start, o_words_sent = 0.
- Count 4'b1111 with MAX_WORDS=8: o_clamp_err pulses, exactly 8 words sent, o_tx_last on the 8th.
- Count 4'b0101, i_tx_ready toggled randomly, i_word_valid gapped: o_tx_data stable while stalled, ordering preserved, exactly 5 words, o_tx_last on 5th only.
- i_frame_start re-pulsed mid-frame with count 4'b0001: o_start_err pulses, original count completes unchanged; new start coincident with o_done is accepted and runs.
- i_rst_n asserted during FLUSH with o_tx_valid high: all outputs 0 immediately, no o_done; the next frame with count 4'b0010 runs normally.
